// File: rtl/ahbl_resp_mem.sv
// AHB-Lite slave with an internal word-addressed memory, programmable wait states
// and two-cycle ERROR responses for illegal accesses.
module ahbl_resp_mem #(
   parameter int unsigned AWIDTH      = 10,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned ERR_ENABLE  = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic [31:0] HWDATA,
   input  logic        HREADYIN,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int unsigned DEPTH = 1 << AWIDTH;
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR1 = 2'd2;
   localparam logic [1:0] ST_ERR2 = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [1:0]        lane_q, lane_d;
   logic [1:0]        size_q, size_d;
   logic              write_q, write_d;
   logic              pend_q, pend_d;
   logic              legal_q, legal_d;

   logic              accept_c;
   logic              illegal_c;
   logic              complete_c;
   logic [3:0]        be_c;

   logic [31:0]       mem_q [DEPTH];

   // Ignored bus attributes
   logic unused_ok;
   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   // Legality, accept and next-state decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      lane_d  = lane_q;
      size_d  = size_q;
      write_d = write_q;
      pend_d  = pend_q;
      legal_d = legal_q;

      illegal_c = (HSIZE > 3'b010)
                | ((HSIZE == 3'b001) & HADDR[0])
                | ((HSIZE == 3'b010) & (|HADDR[1:0]))
                | (|HADDR[31:AWIDTH+2]);
      accept_c   = HSEL & HTRANS[1] & HREADYIN
                 & ((state_q == ST_IDLE) | (state_q == ST_ERR2));
      complete_c = pend_q & (state_q == ST_IDLE);

      case (state_q)
         ST_IDLE, ST_ERR2: begin
            pend_d  = 1'b0;
            state_d = ST_IDLE;
            if (accept_c) begin
               addr_d  = HADDR[AWIDTH+1:2];
               lane_d  = HADDR[1:0];
               size_d  = HSIZE[1:0];
               write_d = HWRITE;
               legal_d = ~illegal_c;
               if (illegal_c && (ERR_ENABLE != 0)) begin
                  state_d = ST_ERR1;
               end else begin
                  pend_d = 1'b1;
                  if (WAIT_STATES != 0) begin
                     state_d = ST_WAIT;
                     cnt_d   = CNT_W'(WAIT_STATES - 1);
                  end
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_ERR2;
      endcase
   end

   // Byte-lane enables for the completing write
   always_comb begin
      be_c = 4'b0000;
      if (complete_c && legal_q && write_q) begin
         case (size_q)
            2'b00:   be_c[lane_q] = 1'b1;
            2'b01:   be_c = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
         endcase
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         pend_q  <= 1'b0;
         legal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         write_q <= write_d;
         pend_q  <= pend_d;
         legal_q <= legal_d;
      end
   end

   // Storage is not reset; an abandoned write never commits because reset clears pend_q
   always_ff @(posedge HCLK) begin
      for (int b = 0; b < 4; b++) begin
         if (be_c[b]) mem_q[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
   end

   assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
   assign HRESP     = state_q[1];
   assign HRDATA    = (complete_c && legal_q && !write_q) ? mem_q[addr_q] : 32'h0;

endmodule

// File: tb/tb_ahbl_resp_mem.sv
// Randomized self-checking bench for ahbl_resp_mem: three instances with different
// wait-state / error settings, checked against a behavioural memory model.
module tb_ahbl_resp_mem;

   localparam int NI = 3;
   localparam int NW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        hsel      [NI];
   logic [31:0] haddr     [NI];
   logic [1:0]  htrans    [NI];
   logic        hwrite    [NI];
   logic [2:0]  hsize     [NI];
   logic [2:0]  hburst    [NI];
   logic [3:0]  hprot     [NI];
   logic        hmastlock [NI];
   logic [31:0] hwdata    [NI];
   logic        hrin      [NI];
   logic        hready    [NI];
   logic        hresp     [NI];
   logic [31:0] hrdata    [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ahbl_resp_mem #(
         .AWIDTH     (10),
         .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2)),
         .ERR_ENABLE (g == 2 ? 0 : 1)
      ) u_dut (
         .HCLK     (clk),
         .HRESET   (rst),
         .HSEL     (hsel[g]),
         .HADDR    (haddr[g]),
         .HTRANS   (htrans[g]),
         .HWRITE   (hwrite[g]),
         .HSIZE    (hsize[g]),
         .HBURST   (hburst[g]),
         .HPROT    (hprot[g]),
         .HMASTLOCK(hmastlock[g]),
         .HWDATA   (hwdata[g]),
         .HREADYIN (hrin[g]),
         .HREADYOUT(hready[g]),
         .HRESP    (hresp[g]),
         .HRDATA   (hrdata[g])
      );
   end

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] mdl [NI][NW];

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
   endfunction

   function automatic bit err_of(input int k);
      return k != 2;
   endfunction

   function automatic bit legal_f(input logic [2:0] sz, input logic [31:0] a);
      if (sz > 3'd2) return 1'b0;
      if ((a % (32'd1 << sz)) != 0) return 1'b0;
      return a < 32'h1000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_addr(input int k, input bit wr, input logic [2:0] sz, input logic [31:0] a);
      hsel[k]      = 1'b1;
      htrans[k]    = 2'b10;
      haddr[k]     = a;
      hwrite[k]    = wr;
      hsize[k]     = sz;
      hburst[k]    = 3'($urandom);
      hprot[k]     = 4'($urandom);
      hmastlock[k] = 1'($urandom);
   endtask

   task automatic drive_idle(input int k);
      htrans[k] = 2'b00;
      hsel[k]   = 1'($urandom);
   endtask

   // One non-overlapped transfer; entered and left just after a rising edge
   task automatic xfer(input int k, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output int waits, output bit err);
      drive_addr(k, wr, sz, a);
      @(posedge clk); #1;
      drive_idle(k);
      hwdata[k] = wd;
      waits = 0;
      err   = 1'b0;
      @(negedge clk);
      while (!hready[k] && waits < 40) begin
         if (hresp[k]) err = 1'b1;
         chk("rdz_wait", hrdata[k], 32'h0);
         waits++;
         @(negedge clk);
      end
      if (hresp[k]) err = 1'b1;
      rd = hrdata[k];
      @(posedge clk); #1;
   endtask

   task automatic do_xfer(input int k, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
      logic [31:0] rd, exp_rd;
      int          waits;
      bit          err, legal, eerr;
      legal  = legal_f(sz, a);
      eerr   = !legal && err_of(k);
      exp_rd = (legal && !wr) ? mdl[k][a[7:2]] : 32'h0;
      xfer(k, wr, sz, a, wd, rd, waits, err);
      chk($sformatf("waits i%0d a%h", k, a), 32'(waits), 32'(eerr ? 1 : ws_of(k)));
      chk($sformatf("resp i%0d a%h", k, a), 32'(err), 32'(eerr));
      chk($sformatf("rdata i%0d a%h", k, a), rd, exp_rd);
      if (legal && wr) begin
         for (int i = 0; i < (1 << sz); i++) begin
            int bi;
            bi = int'(a % 4) + i;
            mdl[k][a[7:2]][8*bi +: 8] = wd[8*bi +: 8];
         end
      end
   endtask

   task automatic rand_xfer(input int k);
      logic [2:0]  sz;
      logic [31:0] a;
      int          w;
      sz = ($urandom % 8 == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
      w  = int'($urandom % NW);
      if ($urandom % 4 == 0)   a = 32'(w * 4 + int'($urandom % 4));
      else if (sz == 3'd0)     a = 32'(w * 4 + int'($urandom % 4));
      else if (sz == 3'd1)     a = 32'(w * 4 + 2 * int'($urandom % 2));
      else                     a = 32'(w * 4);
      if ($urandom % 16 == 0)  a = a | (32'd1 << (12 + $urandom % 20));
      do_xfer(k, 1'($urandom), sz, a, $urandom);
   endtask

   logic [31:0] rd;
   int          waits, n;
   bit          err;

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < NI; k++) begin
         hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = '0; hwrite[k] = 1'b0; hsize[k] = '0;
         hburst[k] = '0; hprot[k] = '0; hmastlock[k] = 1'b0; hwdata[k] = '0; hrin[k] = 1'b1;
         for (int w = 0; w < NW; w++) mdl[k][w] = 32'h0;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_ready", 32'(hready[k]), 32'd1);
         chk("rst_resp", 32'(hresp[k]), 32'd0);
         chk("rst_rdata", hrdata[k], 32'h0);
      end
      @(posedge clk); #1;

      // Back-to-back write then read, zero wait
      drive_addr(0, 1'b1, 3'd2, 32'h10);
      @(posedge clk); #1;
      drive_addr(0, 1'b0, 3'd2, 32'h10);
      hwdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      chk("b2b_wr_ready", 32'(hready[0]), 32'd1);
      chk("b2b_wr_resp", 32'(hresp[0]), 32'd0);
      @(posedge clk); #1;
      drive_idle(0);
      @(negedge clk);
      chk("b2b_rd_ready", 32'(hready[0]), 32'd1);
      chk("b2b_rd_resp", 32'(hresp[0]), 32'd0);
      chk("b2b_rd_data", hrdata[0], 32'hDEADBEEF);
      @(posedge clk); #1;
      mdl[0][4] = 32'hDEADBEEF;

      // Byte lanes
      do_xfer(0, 1'b1, 3'd2, 32'h20, 32'h0);
      do_xfer(0, 1'b1, 3'd0, 32'h23, 32'hAA00_0000);
      do_xfer(0, 1'b1, 3'd1, 32'h20, 32'h0000_5555);
      xfer(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, waits, err);
      chk("lanes_data", rd, 32'hAA005555);

      // Misaligned write is rejected and leaves memory alone
      do_xfer(0, 1'b1, 3'd2, 32'h0, 32'h12345678);
      xfer(0, 1'b1, 3'd2, 32'h2, 32'hFFFFFFFF, rd, waits, err);
      chk("err_waits", 32'(waits), 32'd1);
      chk("err_resp", 32'(err), 32'd1);
      @(negedge clk);
      chk("err_idle_ready", 32'(hready[0]), 32'd1);
      chk("err_idle_resp", 32'(hresp[0]), 32'd0);
      @(posedge clk); #1;
      xfer(0, 1'b0, 3'd2, 32'h0, 32'h0, rd, waits, err);
      chk("err_old_data", rd, 32'h12345678);

      // Out of range and oversize
      xfer(0, 1'b0, 3'd2, 32'h1000, 32'h0, rd, waits, err);
      chk("oor_resp", 32'(err), 32'd1);
      chk("oor_waits", 32'(waits), 32'd1);
      xfer(0, 1'b0, 3'd3, 32'h0, 32'h0, rd, waits, err);
      chk("size3_resp", 32'(err), 32'd1);
      hsel[0] = 1'b1; htrans[0] = 2'b00;
      @(posedge clk); #1;
      htrans[0] = 2'b01;
      @(negedge clk);
      chk("idle_sel_ready", 32'(hready[0]), 32'd1);
      chk("idle_sel_resp", 32'(hresp[0]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_sel_ready", 32'(hready[0]), 32'd1);
      chk("busy_sel_rdata", hrdata[0], 32'h0);
      @(posedge clk); #1;
      drive_idle(0);

      // New transfer accepted in ERR2
      drive_addr(0, 1'b1, 3'd2, 32'h6);
      @(posedge clk); #1;
      drive_idle(0);
      @(negedge clk);
      chk("err1_ready", 32'(hready[0]), 32'd0);
      chk("err1_resp", 32'(hresp[0]), 32'd1);
      @(posedge clk); #1;
      drive_addr(0, 1'b0, 3'd2, 32'h10);
      @(negedge clk);
      chk("err2_ready", 32'(hready[0]), 32'd1);
      chk("err2_resp", 32'(hresp[0]), 32'd1);
      @(posedge clk); #1;
      drive_idle(0);
      @(negedge clk);
      chk("err2_acc_resp", 32'(hresp[0]), 32'd0);
      chk("err2_acc_data", hrdata[0], 32'hDEADBEEF);
      @(posedge clk); #1;

      // Prefill, random traffic and full readback on every instance
      for (int k = 0; k < NI; k++) begin
         for (int w = 0; w < NW; w++) do_xfer(k, 1'b1, 3'd2, 32'(w * 4), $urandom);
         for (int i = 0; i < 150; i++) rand_xfer(k);
         for (int w = 0; w < NW; w++) do_xfer(k, 1'b0, 3'd2, 32'(w * 4), 32'h0);
      end

      // Three wait states; a NONSEQ held during the waits is taken only on the ready cycle
      do_xfer(1, 1'b1, 3'd2, 32'h44, 32'h1111_2222);
      do_xfer(1, 1'b1, 3'd2, 32'h48, 32'h3333_4444);
      drive_addr(1, 1'b0, 3'd2, 32'h44);
      @(posedge clk); #1;
      drive_addr(1, 1'b0, 3'd2, 32'h48);
      for (int p = 0; p < 2; p++) begin
         n = 0;
         @(negedge clk);
         while (!hready[1] && n < 20) begin
            n++;
            @(negedge clk);
         end
         chk($sformatf("ws3_low_cycles_%0d", p), 32'(n), 32'd3);
         chk($sformatf("ws3_data_%0d", p), hrdata[1], (p == 0) ? 32'h1111_2222 : 32'h3333_4444);
         @(posedge clk); #1;
         drive_idle(1);
      end

      // Reset during a write's wait state abandons the write
      do_xfer(1, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D);
      drive_addr(1, 1'b1, 3'd2, 32'h40);
      @(posedge clk); #1;
      drive_idle(1);
      hwdata[1] = 32'h0BADBEEF;
      @(negedge clk);
      chk("rstw_wait_ready", 32'(hready[1]), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("rstw_ready", 32'(hready[1]), 32'd1);
      chk("rstw_resp", 32'(hresp[1]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_xfer(1, 1'b0, 3'd2, 32'h40, 32'h0);
      do_xfer(0, 1'b0, 3'd2, 32'h10, 32'h0);
      do_xfer(2, 1'b0, 3'd2, 32'h10, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
